wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter.sv | 116 +++++++++++
 tb/tb_wb_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the ALU has fixed priority over a 2-entry load FIFO.
// A pending-write scoreboard stalls issue on RAW and WAW hazards.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        stall,
  output logic [4:0]  rd_addr,
  output logic [31:0] w_data,
  output logic        w_en
);

  logic [1:0]  count_q, count_d;
  logic [4:0]  fifo_rd_q   [2];
  logic [31:0] fifo_data_q [2];
  logic        push, pop, alu_sel, wr_idx;

  logic        w_en_q, w_en_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic [31:0] pending_q, pending_d;
  logic        issue_go;

  // A source is busy only while its write has not yet reached the port;
  // the register file bypasses the value in the cycle it is written.
  function automatic logic hit(input logic [4:0] x, input logic [31:0] pend,
                               input logic wen, input logic [4:0] wrd);
    return (x != 5'd0) && pend[x] && !(wen && (wrd == x));
  endfunction

  assign mem_ready = (count_q < 2'd2);
  assign push      = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign alu_sel   = alu_valid && (alu_rd != 5'd0);
  assign pop       = !alu_sel && (count_q != 2'd0);
  // Pushing while popping can only happen at count 1, so the new entry lands at the head.
  assign wr_idx    = pop ? 1'b0 : count_q[0];

  assign stall = issue_valid && (hit(rs1_addr, pending_q, w_en_q, rd_addr_q) ||
                                 hit(rs2_addr, pending_q, w_en_q, rd_addr_q) ||
                                 hit(issue_rd, pending_q, w_en_q, rd_addr_q));
  assign issue_go = issue_valid && !stall && (issue_rd != 5'd0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_d   = count_q;
    w_en_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    w_data_d  = w_data_q;
    pending_d = pending_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (alu_sel) begin
      w_en_d    = 1'b1;
      rd_addr_d = alu_rd;
      w_data_d  = alu_data;
    end else if (pop) begin
      w_en_d    = 1'b1;
      rd_addr_d = fifo_rd_q[0];
      w_data_d  = fifo_data_q[0];
    end

    // Clear before set so a same-edge re-issue keeps the register pending.
    if (w_en_q)   pending_d[rd_addr_q] = 1'b0;
    if (issue_go) pending_d[issue_rd]  = 1'b1;
    pending_d[0] = 1'b0;
  end

  // NOTE: FIFO storage has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (pop) begin
      fifo_rd_q[0]   <= fifo_rd_q[1];
      fifo_data_q[0] <= fifo_data_q[1];
    end
    if (push) begin
      fifo_rd_q[wr_idx]   <= mem_rd;
      fifo_data_q[wr_idx] <= mem_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 2'd0;
      w_en_q    <= 1'b0;
      rd_addr_q <= 5'd0;
      w_data_q  <= 32'd0;
      pending_q <= 32'd0;
    end else begin
      count_q   <= count_d;
      w_en_q    <= w_en_d;
      rd_addr_q <= rd_addr_d;
      w_data_q  <= w_data_d;
      pending_q <= pending_d;
    end
  end

  assign w_en    = w_en_q;
  assign rd_addr = rd_addr_q;
  assign w_data  = w_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a cycle-by-cycle vector table followed by a
// hand-written mid-operation reset sequence.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, issue_valid;
  logic [4:0]  alu_rd, mem_rd, issue_rd, rs1_addr, rs2_addr;
  logic [31:0] alu_data, mem_data;
  logic        mem_ready, stall, w_en;
  logic [4:0]  rd_addr;
  logic [31:0] w_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .stall(stall), .rd_addr(rd_addr), .w_data(w_data), .w_en(w_en)
  );

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic        iv;  logic [4:0] ird; logic [4:0] rs1; logic [4:0] rs2;
    logic        e_stall; logic e_ready;
    logic        e_wen; logic [4:0] e_rd; logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                     input logic iv, input logic [4:0] ird, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic e_stall, input logic e_ready,
                     input logic e_wen, input logic [4:0] e_rd, input logic [31:0] e_data);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
    v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
    v.e_stall = e_stall; v.e_ready = e_ready;
    v.e_wen = e_wen; v.e_rd = e_rd; v.e_data = e_data;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    alu_valid = v.av;  alu_rd = v.ard; alu_data = v.ad;
    mem_valid = v.mv;  mem_rd = v.mrd; mem_data = v.md;
    issue_valid = v.iv; issue_rd = v.ird; rs1_addr = v.rs1; rs2_addr = v.rs2;
  endtask

  task automatic idle();
    vec_t v;
    v.av = 0; v.ard = 0; v.ad = 0; v.mv = 0; v.mrd = 0; v.md = 0;
    v.iv = 0; v.ird = 0; v.rs1 = 0; v.rs2 = 0;
    v.e_stall = 0; v.e_ready = 1; v.e_wen = 0; v.e_rd = 0; v.e_data = 0;
    drive(v);
  endtask

  initial begin
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    //   av ard ad            mv mrd md            iv ird rs1 rs2  stall rdy  wen rd data
    add(0, 0, 0,             0, 0, 0,             1, 5, 0, 0,     0, 1,      0, 0, 0);            // 0 issue x5
    add(1, 5, 32'hDEADBEEF,  0, 0, 0,             0, 0, 0, 0,     0, 1,      1, 5, 32'hDEADBEEF); // 1 ALU write
    add(0, 0, 0,             0, 0, 0,             1, 6, 5, 0,     0, 1,      0, 0, 0);            // 2 bypass x5
    add(0, 0, 0,             0, 0, 0,             1, 0, 5, 0,     0, 1,      0, 0, 0);            // 3 x5 released
    add(0, 0, 0,             0, 0, 0,             1, 0, 0, 6,     1, 1,      0, 0, 0);            // 4 RAW on rs2
    add(0, 0, 0,             0, 0, 0,             1, 3, 0, 0,     0, 1,      0, 0, 0);            // 5 issue x3
    add(0, 0, 0,             0, 0, 0,             1, 4, 0, 0,     0, 1,      0, 0, 0);            // 6 issue x4
    add(1, 3, 32'h33,        1, 4, 32'h44,        0, 0, 0, 0,     0, 1,      1, 3, 32'h33);       // 7 collision
    add(0, 0, 0,             0, 0, 0,             0, 0, 0, 0,     0, 1,      1, 4, 32'h44);       // 8 load drains
    add(0, 0, 0,             0, 0, 0,             1, 0, 4, 0,     0, 1,      0, 0, 0);            // 9 bypass x4
    add(1, 10, 32'hA0,       1, 11, 32'hB1,       0, 0, 0, 0,     0, 1,      1, 10, 32'hA0);      // 10 fill 1
    add(1, 12, 32'hA2,       1, 13, 32'hB3,       0, 0, 0, 0,     0, 1,      1, 12, 32'hA2);      // 11 fill 2
    add(1, 14, 32'hA4,       1, 15, 32'hB5,       0, 0, 0, 0,     0, 0,      1, 14, 32'hA4);      // 12 full
    add(0, 0, 0,             1, 15, 32'hB5,       0, 0, 0, 0,     0, 0,      1, 11, 32'hB1);      // 13 drain head
    add(0, 0, 0,             1, 15, 32'hB5,       0, 0, 0, 0,     0, 1,      1, 13, 32'hB3);      // 14 push+pop
    add(0, 0, 0,             0, 0, 0,             0, 0, 0, 0,     0, 1,      1, 15, 32'hB5);      // 15 last load
    add(0, 0, 0,             0, 0, 0,             0, 0, 0, 0,     0, 1,      0, 0, 0);            // 16 empty
    add(0, 0, 0,             0, 0, 0,             1, 7, 0, 0,     0, 1,      0, 0, 0);            // 17 issue x7
    add(1, 7, 32'h77,        0, 0, 0,             1, 8, 7, 0,     1, 1,      1, 7, 32'h77);       // 18 RAW on rs1
    add(0, 0, 0,             0, 0, 0,             1, 8, 7, 0,     0, 1,      0, 0, 0);            // 19 released
    add(0, 0, 0,             0, 0, 0,             1, 0, 0, 0,     0, 1,      0, 0, 0);            // 20 x0 sources
    add(0, 0, 0,             0, 0, 0,             1, 9, 0, 0,     0, 1,      0, 0, 0);            // 21 issue x9
    add(0, 0, 0,             0, 0, 0,             1, 9, 0, 0,     1, 1,      0, 0, 0);            // 22 WAW
    add(0, 0, 0,             0, 0, 0,             1, 9, 0, 0,     1, 1,      0, 0, 0);            // 23 WAW held
    add(1, 0, 32'hFF,        1, 0, 32'hEE,        1, 0, 0, 0,     0, 1,      0, 0, 0);            // 24 all x0
    add(0, 0, 0,             0, 0, 0,             0, 0, 0, 0,     0, 1,      0, 0, 0);            // 25 x0 load dropped
    add(1, 9, 32'h99,        0, 0, 0,             0, 0, 0, 0,     0, 1,      1, 9, 32'h99);       // 26 write x9
    add(0, 0, 0,             0, 0, 0,             1, 9, 0, 0,     0, 1,      0, 0, 0);            // 27 set beats clear
    add(0, 0, 0,             0, 0, 0,             1, 9, 0, 0,     1, 1,      0, 0, 0);            // 28 x9 still pending
    add(0, 0, 0,             1, 20, 32'hC0,       0, 0, 0, 0,     0, 1,      0, 0, 0);            // 29 load x20
    add(1, 0, 32'h1,         0, 0, 0,             0, 0, 0, 0,     0, 1,      1, 20, 32'hC0);      // 30 x0 ALU, FIFO writes

    rst_n = 1'b0;
    idle();
    #1;
    check("reset w_en", w_en, 0);
    check("reset rd_addr", rd_addr, 0);
    check("reset w_data", w_data, 0);
    check("reset mem_ready", mem_ready, 1);
    check("reset stall", stall, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset w_en", w_en, 0);

    exp_rd = 0;
    exp_data = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d stall", i), stall, vecs[i].e_stall);
      check($sformatf("v%0d mem_ready", i), mem_ready, vecs[i].e_ready);
      @(posedge clk); #1;
      if (vecs[i].e_wen) begin
        exp_rd = vecs[i].e_rd;
        exp_data = vecs[i].e_data;
      end
      check($sformatf("v%0d w_en", i), w_en, vecs[i].e_wen);
      check($sformatf("v%0d rd_addr", i), rd_addr, exp_rd);
      check($sformatf("v%0d w_data", i), w_data, exp_data);
    end

    // Fill the FIFO behind ALU traffic with x6/x8/x9 still pending, then reset.
    idle();
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    mem_valid = 1; mem_rd = 2; mem_data = 32'h22;
    @(posedge clk); #1;
    mem_rd = 3; mem_data = 32'h33;
    @(posedge clk); #1;
    idle();
    issue_valid = 1; rs1_addr = 9;
    #1;
    check("full before reset mem_ready", mem_ready, 0);
    check("pending before reset stall", stall, 1);
    rst_n = 1'b0;
    #1;
    check("mid reset w_en", w_en, 0);
    check("mid reset rd_addr", rd_addr, 0);
    check("mid reset w_data", w_data, 0);
    check("mid reset mem_ready", mem_ready, 1);
    check("mid reset stall", stall, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("after release stall", stall, 0);
    @(posedge clk); #1;
    check("first cycle after release w_en", w_en, 0);
    @(posedge clk); #1;
    check("second cycle after release w_en", w_en, 0);
    check("after release mem_ready", mem_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
